hi_wb_regbank_mc: RTL and testbench
===================================

Name: hi_wb_regbank_mc

Overview:
- Parametrised next-generation Wishbone register bank for the home-inventory chip (Caravel user area), generalised to N_CH sensor channels.
- Keeps the ID/VERSION/CTRL/IRQ_EN/STATUS control plane and adds the following:
  - per-channel sample capture registers with data-ready (DRDY) and overrun (OVR) tracking;
  - a write-1-to-clear IRQ status register and a level interrupt output;
  - saturating per-channel sample counters;
  - a base-address window for the Wishbone slave.

Parameters:
- N_CH, 4: number of channels; legal range 1..16.
- DATA_W, 24: sample width in bits; legal range 1..32. Samples are zero-extended on readback.
- CNT_W, 16: per-channel sample counter width; legal range 1..32.
- BASE_ADDR, 32'h3000_0000: base of the slave window.
- ADR_MASK, 32'h0000_0FFF: offset bits. A request is in-window iff (wbs_adr_i & ~ADR_MASK) == BASE_ADDR.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_i  in  1  synchronous, active-high reset
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic slave strobes
- wbs_sel_i  in  4  byte lanes
- wbs_dat_i  in  32  write data
- wbs_adr_i  in  32  byte address
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- core_status  in  8  raw core status
- ch_valid  in  N_CH  per-channel 1-cycle sample strobe
- ch_data  in  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
- ctrl_enable  out  1  ENABLE bit
- ctrl_start  out  1  1-cycle START pulse
- ctrl_clear  out  1  1-cycle CLR_ALL pulse
- irq  out  1  registered level interrupt

Behaviour:
- Reset (wb_rst_i=1 at a clock edge) clears all of the following to 0: wbs_ack_o, wbs_dat_o, ctrl_enable, ctrl_start, ctrl_clear, irq, IRQ_EN, IRQ_STATUS, all CH_DATA and all CH_COUNT. Reset mid-transaction drops the transaction with no ack.
- Handshake:
  - Accept when cyc&stb&in-window&~wbs_ack_o.
  - wbs_ack_o goes high for exactly 1 cycle, in the cycle after accept. wbs_dat_o is latched in that same cycle.
  - Back-to-back transfers take at least 2 cycles each.
  - Out-of-window requests are never acked and have no side effects.
- Register map (offsets):
  - 0x000 ID, RO, 32'h4849_4348.
  - 0x004 VERSION, RO, 32'h0000_0002.
  - 0x008 PARAMS, RO, {8'h0, CNT_W[7:0], DATA_W[7:0], N_CH[7:0]}.
  - 0x100 CTRL, lane 0 only:
    - bit0 ENABLE: RW, sticky.
    - bit1 START: write-1 pulses ctrl_start; reads 0.
    - bit2 CLR_ALL: write-1 pulses ctrl_clear; reads 0. Also clears IRQ_STATUS and all CH_COUNT in the same edge.
  - 0x104 IRQ_EN, RW, byte-lane masked. Only the implemented bits [N_CH-1:0] and [16+N_CH-1:16] are stored; other bits read 0.
  - 0x108 STATUS, RO, {24'h0, core_status}.
  - 0x10C IRQ_STATUS, W1C per lane:
    - bits [N_CH-1:0]: DRDY[i].
    - bits [16+i]: OVR[i].
  - 0x200+4i CH_DATA[i], RO, zero-extended. An accepted read clears DRDY[i].
  - 0x300+4i CH_COUNT[i], RO. Counts captured samples and saturates at all-ones.
  - Unmapped in-window offsets, and channels i>=N_CH, are acked, read 0, and ignore writes.
- Capture, per channel, when ch_valid[i]&ENABLE:
  - CH_DATA[i] <= sample.
  - DRDY[i] <= 1.
  - CH_COUNT[i] increments unless saturated.
  - If DRDY[i] was already 1 and is not being cleared in this cycle, set OVR[i].
  - When ENABLE=0, ch_valid is ignored.
- Simultaneous events:
  - A hardware set beats a W1C or read-clear in the same cycle.
  - A CH_DATA read in a capture cycle returns the old value; DRDY ends at 1.
  - A capture beats CLR_ALL for that channel: DRDY=1, count=1.
- irq <= |(IRQ_STATUS & IRQ_EN), registered, so it lags the status by 1 cycle.

Test Plan:
- Reset, then read 0x000/0x004/0x008 with defaults -> 4849_4348, 0000_0002, 0010_1804; each ack 1 cycle wide, 1 cycle after accept.
- ENABLE=1, IRQ_EN=0x1. Pulse ch_valid[0] with data 0xABCDEF:
  - IRQ_STATUS=0x1; irq=1 one cycle later.
  - Read CH_DATA[0] -> 0x00ABCDEF; DRDY0 cleared; irq drops next cycle.
- Two ch_valid[2] pulses with no read -> IRQ_STATUS=0x0004_0004, CH_COUNT[2]=2. Write 0x0004_0000 to 0x10C -> 0x0000_0004.
- ch_valid[1] in the same cycle as a W1C of bit1 -> DRDY1 stays 1. With ENABLE=0, a ch_valid pulse changes nothing.
- CNT_W=4: 17 captures -> CH_COUNT=0xF. Write CTRL=0x5 -> ctrl_clear pulses for 1 cycle, counts and status become 0, ENABLE stays 1.
- Address BASE_ADDR+0x1000 -> no ack. Offset 0x200+4*N_CH reads 0. Assert reset in the accept cycle -> no ack.

Source files
------------

// File: rtl/hi_wb_regbank_mc_if.sv
// Wishbone classic slave signal bundle for the register bank.
// Direction suffixes follow the slave's point of view.
interface hi_wb_regbank_mc_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_dat_i;
   logic [31:0] wbs_adr_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      output wbs_ack_o, wbs_dat_o
   );
   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/hi_wb_regbank_mc.sv
// N_CH-channel Wishbone register bank: capture/DRDY/OVR, W1C IRQ status, saturating counters.
// Ack 1 cycle after accept, no wait states; ack blocks the next accept so each transfer takes 2+ cycles.
module hi_wb_regbank_mc #(
   parameter int          N_CH      = 4,
   parameter int          DATA_W    = 24,
   parameter int          CNT_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ADR_MASK  = 32'h0000_0FFF
) (
   input  logic                     wb_clk_i,
   input  logic                     wb_rst_i,
   hi_wb_regbank_mc_if.slave        wbs,
   input  logic [7:0]               core_status,
   input  logic [N_CH-1:0]          ch_valid,
   input  logic [N_CH*DATA_W-1:0]   ch_data,
   output logic                     ctrl_enable,
   output logic                     ctrl_start,
   output logic                     ctrl_clear,
   output logic                     irq
);
   localparam logic [31:0] ID_VAL  = 32'h4849_4348;
   localparam logic [31:0] VER_VAL = 32'h0000_0002;
   localparam logic [31:0] PARAMS  = {8'h0, 8'(CNT_W), 8'(DATA_W), 8'(N_CH)};
   localparam logic [31:0] CH_LO   = 32'((33'd1 << N_CH) - 33'd1);
   localparam logic [31:0] IMPL    = CH_LO | (CH_LO << 16);

   logic                r_ack;
   logic [31:0]         r_dat;
   logic                r_enable, r_start, r_clear, r_irq;
   logic [31:0]         r_irq_en;
   logic [N_CH-1:0]     r_drdy, r_ovr;
   logic [DATA_W-1:0]   r_data [N_CH];
   logic [CNT_W-1:0]    r_cnt  [N_CH];

   logic [31:0]         w_off, w_rdata, w_sts;
   logic [3:0]          w_idx;
   logic                w_acc, w_wr, w_rd, w_ctrl_wr, w_start, w_clr;
   logic                w_en_wr, w_sts_wr, w_dhit, w_chit;
   logic [N_CH-1:0]     w_cap, w_drdy_clr, w_ovr_clr;

   assign w_off     = wbs.wbs_adr_i & ADR_MASK;
   assign w_idx     = w_off[5:2];
   assign w_acc     = wbs.wbs_cyc_i & wbs.wbs_stb_i & ~r_ack &
                      ((wbs.wbs_adr_i & ~ADR_MASK) == BASE_ADDR);
   assign w_wr      = w_acc & wbs.wbs_we_i;
   assign w_rd      = w_acc & ~wbs.wbs_we_i;
   assign w_ctrl_wr = w_wr & (w_off == 32'h100) & wbs.wbs_sel_i[0];
   assign w_start   = w_ctrl_wr & wbs.wbs_dat_i[1];
   assign w_clr     = w_ctrl_wr & wbs.wbs_dat_i[2];
   assign w_en_wr   = w_wr & (w_off == 32'h104);
   assign w_sts_wr  = w_wr & (w_off == 32'h10C);
   assign w_dhit    = (w_off[31:8] == 24'h2) && (w_off[7:6] == 2'b0) && (w_off[1:0] == 2'b0);
   assign w_chit    = (w_off[31:8] == 24'h3) && (w_off[7:6] == 2'b0) && (w_off[1:0] == 2'b0);

   always_comb begin
      w_sts = '0;
      w_sts[N_CH-1:0]  = r_drdy;
      w_sts[16 +: N_CH] = r_ovr;
   end

   always_comb begin
      w_rdata = '0;
      case (w_off)
         32'h000: w_rdata = ID_VAL;
         32'h004: w_rdata = VER_VAL;
         32'h008: w_rdata = PARAMS;
         32'h100: w_rdata = {31'h0, r_enable};
         32'h104: w_rdata = r_irq_en;
         32'h108: w_rdata = {24'h0, core_status};
         32'h10C: w_rdata = w_sts;
         default: ;
      endcase
      // Channel windows: indices beyond N_CH never match and so read 0.
      for (int i = 0; i < N_CH; i++) begin
         if (w_dhit && w_idx == 4'(i)) w_rdata = 32'(r_data[i]);
         if (w_chit && w_idx == 4'(i)) w_rdata = 32'(r_cnt[i]);
      end
   end

   always_comb begin
      w_cap      = '0;
      w_drdy_clr = '0;
      w_ovr_clr  = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_cap[i]      = ch_valid[i] & r_enable;
         w_drdy_clr[i] = (w_sts_wr & wbs.wbs_sel_i[i/8] & wbs.wbs_dat_i[i]) |
                         (w_rd & w_dhit & (w_idx == 4'(i))) | w_clr;
         w_ovr_clr[i]  = (w_sts_wr & wbs.wbs_sel_i[(16+i)/8] & wbs.wbs_dat_i[16+i]) | w_clr;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_ack    <= 1'b0;
         r_dat    <= '0;
         r_enable <= 1'b0;
         r_start  <= 1'b0;
         r_clear  <= 1'b0;
         r_irq    <= 1'b0;
         r_irq_en <= '0;
      end else begin
         r_ack   <= w_acc;
         r_start <= w_start;
         r_clear <= w_clr;
         r_irq   <= |(w_sts & r_irq_en);
         if (w_acc)     r_dat    <= w_rdata;
         if (w_ctrl_wr) r_enable <= wbs.wbs_dat_i[0];
         if (w_en_wr) begin
            for (int b = 0; b < 4; b++)
               if (wbs.wbs_sel_i[b]) r_irq_en[8*b +: 8] <= wbs.wbs_dat_i[8*b +: 8] & IMPL[8*b +: 8];
         end
      end
   end

   // A capture always wins over software clears of the same channel.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_drdy <= '0;
         r_ovr  <= '0;
         for (int i = 0; i < N_CH; i++) begin
            r_data[i] <= '0;
            r_cnt[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            if (w_cap[i]) begin
               r_data[i] <= ch_data[i*DATA_W +: DATA_W];
               r_drdy[i] <= 1'b1;
               if (w_clr)               r_cnt[i] <= CNT_W'(1);
               else if (r_cnt[i] != '1) r_cnt[i] <= r_cnt[i] + 1'b1;
               if (r_drdy[i] & ~w_drdy_clr[i]) r_ovr[i] <= 1'b1;
               else if (w_ovr_clr[i])          r_ovr[i] <= 1'b0;
            end else begin
               if (w_drdy_clr[i]) r_drdy[i] <= 1'b0;
               if (w_ovr_clr[i])  r_ovr[i]  <= 1'b0;
               if (w_clr)         r_cnt[i]  <= '0;
            end
         end
      end
   end

   assign wbs.wbs_ack_o = r_ack;
   assign wbs.wbs_dat_o = r_dat;
   assign ctrl_enable   = r_enable;
   assign ctrl_start    = r_start;
   assign ctrl_clear    = r_clear;
   assign irq           = r_irq;
endmodule

// File: tb/tb_hi_wb_regbank_mc.sv
// Directed bench: default instance plus a CNT_W=4 instance driven in lockstep.
module tb_hi_wb_regbank_mc;
   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk = 1'b0, rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0, wdat = '0;
   logic [7:0]  core_status = 8'h5A;
   logic [3:0]  ch_valid = '0;
   logic [95:0] ch_data = '0;
   logic        en_a, start_a, clear_a, irq_a;
   logic        en_b, start_b, clear_b, irq_b;

   int          n_vec = 0, n_err = 0;
   int          lat;
   logic [31:0] rd_a, rd_b;
   logic        tail, clr_ack, clr_tail, start_ack, start_tail;

   hi_wb_regbank_mc_if bus_a ();
   hi_wb_regbank_mc_if bus_b ();
   assign bus_a.wbs_cyc_i = cyc;  assign bus_b.wbs_cyc_i = cyc;
   assign bus_a.wbs_stb_i = stb;  assign bus_b.wbs_stb_i = stb;
   assign bus_a.wbs_we_i  = we;   assign bus_b.wbs_we_i  = we;
   assign bus_a.wbs_sel_i = sel;  assign bus_b.wbs_sel_i = sel;
   assign bus_a.wbs_adr_i = adr;  assign bus_b.wbs_adr_i = adr;
   assign bus_a.wbs_dat_i = wdat; assign bus_b.wbs_dat_i = wdat;

   hi_wb_regbank_mc u_dut_a (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus_a), .core_status(core_status),
      .ch_valid(ch_valid), .ch_data(ch_data), .ctrl_enable(en_a),
      .ctrl_start(start_a), .ctrl_clear(clear_a), .irq(irq_a));

   hi_wb_regbank_mc #(.CNT_W(4)) u_dut_b (
      .wb_clk_i(clk), .wb_rst_i(rst), .wbs(bus_b), .core_status(core_status),
      .ch_valid(ch_valid), .ch_data(ch_data), .ctrl_enable(en_b),
      .ctrl_start(start_b), .ctrl_clear(clear_b), .irq(irq_b));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [95:0] mk(input int ch, input logic [23:0] v);
      logic [95:0] r;
      r = '0;
      r[ch*24 +: 24] = v;
      return r;
   endfunction

   task automatic wb_cycle(input logic w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [3:0] vp, input logic [95:0] vd);
      cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
      if (vp != 4'h0) begin
         ch_valid = vp;
         ch_data  = vd;
      end
      lat = -1;
      for (int n = 1; n <= 4; n++) begin
         @(posedge clk); #1;
         ch_valid = '0;
         if (bus_a.wbs_ack_o) begin
            lat = n; rd_a = bus_a.wbs_dat_o; rd_b = bus_b.wbs_dat_o;
            clr_ack = clear_a; start_ack = start_a;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      @(posedge clk); #1;
      tail = bus_a.wbs_ack_o; clr_tail = clear_a; start_tail = start_a;
   endtask

   task automatic wr(input string tag, input logic [31:0] off, input logic [31:0] d,
                     input logic [3:0] s, input logic [3:0] vp, input logic [95:0] vd);
      wb_cycle(1'b1, BASE + off, d, s, vp, vd);
      chk({tag, "_ack"}, 32'(lat), 32'd1);
   endtask

   task automatic rd2(input string tag, input logic [31:0] off,
                      input logic [31:0] exp_a, input logic [31:0] exp_b);
      wb_cycle(1'b0, BASE + off, 32'h0, 4'hF, 4'h0, '0);
      chk({tag, "_lat"}, 32'(lat), 32'd1);
      chk(tag, rd_a, exp_a);
      chk({tag, "_b"}, rd_b, exp_b);
   endtask

   task automatic rd(input string tag, input logic [31:0] off, input logic [31:0] exp);
      rd2(tag, off, exp, exp);
   endtask

   task automatic pulse(input int ch, input logic [23:0] v);
      ch_valid = 4'b0001 << ch;
      ch_data  = mk(ch, v);
      @(posedge clk); #1;
      ch_valid = '0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_ack", {31'h0, bus_a.wbs_ack_o}, 32'h0);
      chk("rst_dat", bus_a.wbs_dat_o, 32'h0);
      chk("rst_en", {31'h0, en_a}, 32'h0);
      chk("rst_irq", {31'h0, irq_a}, 32'h0);
      chk("rst_pulses", {30'h0, start_a, clear_a}, 32'h0);

      rd("id", 32'h000, 32'h4849_4348);
      chk("id_ack_width", {31'h0, tail}, 32'h0);
      rd("ver", 32'h004, 32'h0000_0002);
      chk("ver_ack_width", {31'h0, tail}, 32'h0);
      rd2("params", 32'h008, 32'h0010_1804, 32'h0004_1804);
      rd("status", 32'h108, 32'h0000_005A);
      rd("irq_en_rst", 32'h104, 32'h0);
      rd("irq_sts_rst", 32'h10C, 32'h0);

      wr("en_wr", 32'h100, 32'h1, 4'hF, 4'h0, '0);
      chk("enable", {31'h0, en_a}, 32'h1);
      rd("ctrl_rd", 32'h100, 32'h1);
      wr("ien_all", 32'h104, 32'hFFFF_FFFF, 4'hF, 4'h0, '0);
      rd("ien_mask", 32'h104, 32'h000F_000F);
      wr("ien_lane", 32'h104, 32'h0, 4'b0100, 4'h0, '0);
      rd("ien_lane_rd", 32'h104, 32'h0000_000F);
      wr("ien_1", 32'h104, 32'h1, 4'hF, 4'h0, '0);
      rd("ien_1_rd", 32'h104, 32'h1);

      pulse(0, 24'hABCDEF);
      chk("irq_lag", {31'h0, irq_a}, 32'h0);
      @(posedge clk); #1;
      chk("irq_set", {31'h0, irq_a}, 32'h1);
      rd("sts_ch0", 32'h10C, 32'h1);
      rd("data0", 32'h200, 32'h00AB_CDEF);
      chk("irq_drop", {31'h0, irq_a}, 32'h0);
      rd("sts_clr0", 32'h10C, 32'h0);
      rd("cnt0", 32'h300, 32'h1);

      pulse(2, 24'h111111);
      pulse(2, 24'h222222);
      rd("sts_ovr2", 32'h10C, 32'h0004_0004);
      rd("cnt2", 32'h308, 32'h2);
      wr("w1c_ovr", 32'h10C, 32'h0004_0000, 4'hF, 4'h0, '0);
      rd("sts_w1c_ovr", 32'h10C, 32'h0000_0004);
      wr("w1c_badlane", 32'h10C, 32'h4, 4'b1110, 4'h0, '0);
      rd("sts_badlane", 32'h10C, 32'h0000_0004);
      wr("w1c_drdy", 32'h10C, 32'h4, 4'hF, 4'h0, '0);
      rd("sts_w1c_drdy", 32'h10C, 32'h0);

      pulse(1, 24'h333333);
      wr("w1c_vs_cap", 32'h10C, 32'h2, 4'hF, 4'b0010, mk(1, 24'h444444));
      rd("sts_hw_wins", 32'h10C, 32'h0000_0002);
      rd("cnt1", 32'h304, 32'h2);
      rd("data1", 32'h204, 32'h0044_4444);
      rd("sts_after1", 32'h10C, 32'h0);

      pulse(3, 24'h555555);
      wb_cycle(1'b0, BASE + 32'h20C, 32'h0, 4'hF, 4'b1000, mk(3, 24'h666666));
      chk("rd_vs_cap_old", rd_a, 32'h0055_5555);
      rd("sts_rd_vs_cap", 32'h10C, 32'h0000_0008);
      rd("data3_new", 32'h20C, 32'h0066_6666);
      rd("sts_after3", 32'h10C, 32'h0);

      wr("dis", 32'h100, 32'h0, 4'hF, 4'h0, '0);
      chk("disabled", {31'h0, en_a}, 32'h0);
      pulse(0, 24'h777777);
      rd("dis_sts", 32'h10C, 32'h0);
      rd("dis_data", 32'h200, 32'h00AB_CDEF);
      rd("dis_cnt", 32'h300, 32'h1);

      wr("reen", 32'h100, 32'h1, 4'hF, 4'h0, '0);
      for (int k = 0; k < 17; k++) pulse(0, 24'(k));
      rd2("cnt_sat", 32'h300, 32'h12, 32'hF);
      rd("sts_sat", 32'h10C, 32'h0001_0001);
      wr("clr_all", 32'h100, 32'h5, 4'hF, 4'h0, '0);
      chk("clr_pulse", {31'h0, clr_ack}, 32'h1);
      chk("clr_pulse_end", {31'h0, clr_tail}, 32'h0);
      chk("clr_no_start", {31'h0, start_ack}, 32'h0);
      chk("clr_en_kept", {31'h0, en_a}, 32'h1);
      rd("cnt_cleared", 32'h300, 32'h0);
      rd("sts_cleared", 32'h10C, 32'h0);
      wr("clr_vs_cap", 32'h100, 32'h5, 4'hF, 4'b0100, mk(2, 24'h888888));
      rd("cap_beats_clr_cnt", 32'h308, 32'h1);
      rd("cap_beats_clr_sts", 32'h10C, 32'h4);
      wr("start", 32'h100, 32'h3, 4'hF, 4'h0, '0);
      chk("start_pulse", {31'h0, start_ack}, 32'h1);
      chk("start_pulse_end", {31'h0, start_tail}, 32'h0);
      rd("ctrl_rd_start", 32'h100, 32'h1);

      wb_cycle(1'b0, BASE + 32'h1000, 32'h0, 4'hF, 4'h0, '0);
      chk("oow_rd_noack", 32'(lat), 32'hFFFF_FFFF);
      wb_cycle(1'b1, BASE + 32'h1104, 32'hF, 4'hF, 4'h0, '0);
      chk("oow_wr_noack", 32'(lat), 32'hFFFF_FFFF);
      rd("oow_no_effect", 32'h104, 32'h1);
      rd("ch_oor", 32'h210, 32'h0);
      rd("unmapped", 32'h00C, 32'h0);

      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; rst = 1'b1;
      @(posedge clk); #1;
      chk("rst_acc_noack", {31'h0, bus_a.wbs_ack_o}, 32'h0);
      cyc = 1'b0; stb = 1'b0; rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_acc_noack2", {31'h0, bus_a.wbs_ack_o}, 32'h0);
      chk("rst_acc_en", {31'h0, en_a}, 32'h0);
      rd("rst_acc_ien", 32'h104, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
